control_sequencer: RTL and testbench

//   Microcode sequencer for the SAP-U datapath: steps T-states and drives every
//   bus-enable/load strobe for PC, MAR/RAM, IR, register A, register B, ALU and

---
 rtl/control_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcode sequencer for the SAP-U datapath. It steps through the T-states
//   and drives every bus-enable and load strobe for PC, MAR/RAM, IR, A, B,
//   the ALU and the output register. The decode is built so that at most one
//   bus driver is active in any cycle.
//
// Parameters
//   OPCODE_W   width of the opcode field (IR[7:4])
//   EARLY_END  1: return to T0 right after an instruction's last active step
//              0: always run T0..T4
//
// Ports
//   clk                 in   rising-edge system clock
//   reset               in   asynchronous reset, active-low
//   opcode              in   IR upper nibble, stable from T2 to end of instr
//   run                 in   1: advance every clock, 0: single-step mode
//   step                in   single-step request (used only when run=0)
//   pc_out              out  PC drives bus
//   pc_inc              out  PC increment
//   pc_load             out  PC loads from bus
//   ram_load_mar_reg    out  MAR loads from bus
//   ram_output_enable   out  RAM drives bus
//   ram_control_signal  out  RAM write strobe
//   ir_load_n           out  IR loads from bus (active-low)
//   ir_out_n            out  IR low nibble drives bus (active-low)
//   reg_a_load_n        out  A loads from bus (active-low)
//   reg_a_bus_enable_n  out  A drives bus (active-low)
//   reg_b_load_n        out  B loads from bus (active-low)
//   alu_enable          out  ALU drives bus
//   alu_subtract        out  ALU subtract select
//   out_load            out  output register loads from bus
//   halted              out  sequencer is in HALT
//   t_state             out  current T-state 0-4, 7 = HALT
module control_sequencer #(
  parameter int OPCODE_W  = 4,
  parameter int EARLY_END = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                run,
  input  logic                step,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                ram_load_mar_reg,
  output logic                ram_output_enable,
  output logic                ram_control_signal,
  output logic                ir_load_n,
  output logic                ir_out_n,
  output logic                reg_a_load_n,
  output logic                reg_a_bus_enable_n,
  output logic                reg_b_load_n,
  output logic                alu_enable,
  output logic                alu_subtract,
  output logic                out_load,
  output logic                halted,
  output logic [2:0]          t_state
);

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd7
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h0);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

  state_t state, state_nxt;
  logic   advance;

  // Active-high decode, gated by reset below.
  logic d_pc_out, d_pc_inc, d_pc_load, d_mar_load, d_ram_out, d_ram_we;
  logic d_ir_load, d_ir_out, d_a_load, d_a_out, d_b_load;
  logic d_alu_en, d_alu_sub, d_out_load;

  // step only matters in single-step mode.
  assign advance = run | step;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= T0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: the early exits shorten instructions whose remaining steps are idle.
  always_comb begin
    state_nxt = state;
    if (advance) begin
      unique case (state)
        T0: state_nxt = T1;
        T1: state_nxt = T2;
        T2: begin
          if (opcode == OP_HLT) begin
            state_nxt = HALT;
          end else if ((EARLY_END != 0) &&
                       (opcode != OP_LDA) && (opcode != OP_ADD) &&
                       (opcode != OP_SUB) && (opcode != OP_STA)) begin
            state_nxt = T0;
          end else begin
            state_nxt = T3;
          end
        end
        T3: begin
          if ((EARLY_END != 0) && ((opcode == OP_LDA) || (opcode == OP_STA))) begin
            state_nxt = T0;
          end else begin
            state_nxt = T4;
          end
        end
        T4:      state_nxt = T0;
        HALT:    state_nxt = HALT;
        default: state_nxt = T0;
      endcase
    end
  end

  // Strobe decode from state and opcode. Each state/opcode pair selects at
  // most one bus driver.
  always_comb begin
    d_pc_out   = 1'b0;
    d_pc_inc   = 1'b0;
    d_pc_load  = 1'b0;
    d_mar_load = 1'b0;
    d_ram_out  = 1'b0;
    d_ram_we   = 1'b0;
    d_ir_load  = 1'b0;
    d_ir_out   = 1'b0;
    d_a_load   = 1'b0;
    d_a_out    = 1'b0;
    d_b_load   = 1'b0;
    d_alu_en   = 1'b0;
    d_alu_sub  = 1'b0;
    d_out_load = 1'b0;
    unique case (state)
      T0: begin
        d_pc_out   = 1'b1;
        d_mar_load = 1'b1;
      end
      T1: begin
        d_ram_out = 1'b1;
        d_ir_load = 1'b1;
        d_pc_inc  = 1'b1;
      end
      T2: begin
        unique case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            d_ir_out   = 1'b1;
            d_mar_load = 1'b1;
          end
          OP_LDI: begin
            d_ir_out = 1'b1;
            d_a_load = 1'b1;
          end
          OP_JMP: begin
            d_ir_out  = 1'b1;
            d_pc_load = 1'b1;
          end
          OP_OUT: begin
            d_a_out    = 1'b1;
            d_out_load = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        unique case (opcode)
          OP_LDA: begin
            d_ram_out = 1'b1;
            d_a_load  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            d_ram_out = 1'b1;
            d_b_load  = 1'b1;
            d_alu_sub = (opcode == OP_SUB);
          end
          OP_STA: begin
            d_a_out  = 1'b1;
            d_ram_we = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
          d_alu_en  = 1'b1;
          d_a_load  = 1'b1;
          d_alu_sub = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // Reset gates the outputs combinationally so nothing is driven while it is held.
  assign pc_out             = reset & d_pc_out;
  assign pc_inc             = reset & d_pc_inc;
  assign pc_load            = reset & d_pc_load;
  assign ram_load_mar_reg   = reset & d_mar_load;
  assign ram_output_enable  = reset & d_ram_out;
  assign ram_control_signal = reset & d_ram_we;
  assign ir_load_n          = ~(reset & d_ir_load);
  assign ir_out_n           = ~(reset & d_ir_out);
  assign reg_a_load_n       = ~(reset & d_a_load);
  assign reg_a_bus_enable_n = ~(reset & d_a_out);
  assign reg_b_load_n       = ~(reset & d_b_load);
  assign alu_enable         = reset & d_alu_en;
  assign alu_subtract       = reset & d_alu_sub;
  assign out_load           = reset & d_out_load;
  assign halted             = reset & (state == HALT);
  assign t_state            = reset ? state : 3'd0;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       run;
  logic       step;

  // Instance 0: EARLY_END=1
  logic pc_out0, pc_inc0, pc_load0, mar0, ram_oe0, ram_we0, ir_load_n0, ir_out_n0;
  logic a_load_n0, a_out_n0, b_load_n0, alu_en0, alu_sub0, out_load0, halted0;
  logic [2:0] t0;
  // Instance 1: EARLY_END=0
  logic pc_out1, pc_inc1, pc_load1, mar1, ram_oe1, ram_we1, ir_load_n1, ir_out_n1;
  logic a_load_n1, a_out_n1, b_load_n1, alu_en1, alu_sub1, out_load1, halted1;
  logic [2:0] t1;

  int vecs = 0;
  int fails = 0;
  int mon_vecs = 0;
  int mon_fails = 0;

  control_sequencer #(.OPCODE_W(4), .EARLY_END(1)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .run(run), .step(step),
    .pc_out(pc_out0), .pc_inc(pc_inc0), .pc_load(pc_load0),
    .ram_load_mar_reg(mar0), .ram_output_enable(ram_oe0), .ram_control_signal(ram_we0),
    .ir_load_n(ir_load_n0), .ir_out_n(ir_out_n0), .reg_a_load_n(a_load_n0),
    .reg_a_bus_enable_n(a_out_n0), .reg_b_load_n(b_load_n0), .alu_enable(alu_en0),
    .alu_subtract(alu_sub0), .out_load(out_load0), .halted(halted0), .t_state(t0)
  );

  control_sequencer #(.OPCODE_W(4), .EARLY_END(0)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .run(run), .step(step),
    .pc_out(pc_out1), .pc_inc(pc_inc1), .pc_load(pc_load1),
    .ram_load_mar_reg(mar1), .ram_output_enable(ram_oe1), .ram_control_signal(ram_we1),
    .ir_load_n(ir_load_n1), .ir_out_n(ir_out_n1), .reg_a_load_n(a_load_n1),
    .reg_a_bus_enable_n(a_out_n1), .reg_b_load_n(b_load_n1), .alu_enable(alu_en1),
    .alu_subtract(alu_sub1), .out_load(out_load1), .halted(halted1), .t_state(t1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector bit positions (active-high view).
  localparam logic [14:0] PC_OUT  = 15'h4000;
  localparam logic [14:0] PC_INC  = 15'h2000;
  localparam logic [14:0] PC_LOAD = 15'h1000;
  localparam logic [14:0] MAR     = 15'h0800;
  localparam logic [14:0] RAM_OE  = 15'h0400;
  localparam logic [14:0] RAM_WE  = 15'h0200;
  localparam logic [14:0] IR_LD   = 15'h0100;
  localparam logic [14:0] IR_OUT  = 15'h0080;
  localparam logic [14:0] A_LD    = 15'h0040;
  localparam logic [14:0] A_OUT   = 15'h0020;
  localparam logic [14:0] B_LD    = 15'h0010;
  localparam logic [14:0] ALU_EN  = 15'h0008;
  localparam logic [14:0] ALU_SUB = 15'h0004;
  localparam logic [14:0] OUT_LD  = 15'h0002;
  localparam logic [14:0] HALTED  = 15'h0001;
  localparam logic [14:0] NONE    = 15'h0000;
  // Active-low strobes read 1 when idle.
  localparam logic [14:0] LOW_MASK = 15'h01F0;

  function automatic logic [17:0] pack0();
    return {t0, pc_out0, pc_inc0, pc_load0, mar0, ram_oe0, ram_we0, ir_load_n0, ir_out_n0,
            a_load_n0, a_out_n0, b_load_n0, alu_en0, alu_sub0, out_load0, halted0};
  endfunction

  function automatic logic [17:0] pack1();
    return {t1, pc_out1, pc_inc1, pc_load1, mar1, ram_oe1, ram_we1, ir_load_n1, ir_out_n1,
            a_load_n1, a_out_n1, b_load_n1, alu_en1, alu_sub1, out_load1, halted1};
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [2:0] t,
                     input logic [14:0] act);
    logic [17:0] exp;
    exp = {t, act ^ LOW_MASK};
    vecs++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus-driver contention monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      mon_vecs++;
      assert ((32'(pc_out0) + 32'(ram_oe0) + 32'(!ir_out_n0) + 32'(!a_out_n0) + 32'(alu_en0)) <= 1
              && (32'(pc_out1) + 32'(ram_oe1) + 32'(!ir_out_n1) + 32'(!a_out_n1) + 32'(alu_en1)) <= 1)
      else begin
        mon_fails++;
        $error("FAIL bus_onehot t0=%0d t1=%0d opcode=%0h", t0, t1, opcode);
      end
    end
  end

  initial begin
    reset  = 1'b0;
    run    = 1'b1;
    step   = 1'b0;
    opcode = 4'h1;

    // Reset held with run=1: everything idle.
    repeat (3) tick();
    chk("reset_hold", pack0(), 3'd0, NONE);
    reset = 1'b1;
    #1;
    chk("reset_release_T0", pack0(), 3'd0, PC_OUT | MAR);

    // ADD with early end: 0,1,2,3,4,0
    tick(); chk("add_T1", pack0(), 3'd1, RAM_OE | IR_LD | PC_INC);
    tick(); chk("add_T2", pack0(), 3'd2, IR_OUT | MAR);
    tick(); chk("add_T3", pack0(), 3'd3, RAM_OE | B_LD);
    tick(); chk("add_T4", pack0(), 3'd4, ALU_EN | A_LD);
    tick(); chk("add_T0", pack0(), 3'd0, PC_OUT | MAR);

    // SUB
    opcode = 4'h2;
    tick(); chk("sub_T1", pack0(), 3'd1, RAM_OE | IR_LD | PC_INC);
    tick(); chk("sub_T2", pack0(), 3'd2, IR_OUT | MAR);
    tick(); chk("sub_T3", pack0(), 3'd3, RAM_OE | B_LD | ALU_SUB);
    tick(); chk("sub_T4", pack0(), 3'd4, ALU_EN | A_LD | ALU_SUB);
    tick(); chk("sub_T0", pack0(), 3'd0, PC_OUT | MAR);

    // LDI: 0,1,2,0
    opcode = 4'h5;
    tick(); chk("ldi_T1", pack0(), 3'd1, RAM_OE | IR_LD | PC_INC);
    tick(); chk("ldi_T2", pack0(), 3'd2, IR_OUT | A_LD);
    tick(); chk("ldi_T0", pack0(), 3'd0, PC_OUT | MAR);

    // LDA and STA end after T3, OUT after T2.
    opcode = 4'h0;
    tick(); tick();
    tick(); chk("lda_T3", pack0(), 3'd3, RAM_OE | A_LD);
    tick(); chk("lda_T0", pack0(), 3'd0, PC_OUT | MAR);
    opcode = 4'h4;
    tick(); tick(); chk("sta_T2", pack0(), 3'd2, IR_OUT | MAR);
    tick(); chk("sta_T3", pack0(), 3'd3, A_OUT | RAM_WE);
    tick(); chk("sta_T0", pack0(), 3'd0, PC_OUT | MAR);
    opcode = 4'hE;
    tick(); tick(); chk("out_T2", pack0(), 3'd2, A_OUT | OUT_LD);
    tick(); chk("out_T0", pack0(), 3'd0, PC_OUT | MAR);

    // JMP on both instances from a fresh reset.
    reset = 1'b0;
    opcode = 4'h6;
    tick();
    reset = 1'b1;
    #1;
    chk("jmp_full_T0", pack1(), 3'd0, PC_OUT | MAR);
    tick(); chk("jmp_full_T1", pack1(), 3'd1, RAM_OE | IR_LD | PC_INC);
    tick();
    chk("jmp_full_T2", pack1(), 3'd2, IR_OUT | PC_LOAD);
    chk("jmp_early_T2", pack0(), 3'd2, IR_OUT | PC_LOAD);
    tick();
    chk("jmp_full_T3", pack1(), 3'd3, NONE);
    chk("jmp_early_T0", pack0(), 3'd0, PC_OUT | MAR);
    tick(); chk("jmp_full_T4", pack1(), 3'd4, NONE);
    tick(); chk("jmp_full_T0b", pack1(), 3'd0, PC_OUT | MAR);

    // Single-step mode.
    reset = 1'b0;
    run = 1'b0;
    step = 1'b0;
    opcode = 4'h1;
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("step_frozen", pack0(), 3'd0, PC_OUT | MAR);
    step = 1'b1; tick(); step = 1'b0;
    chk("step_T1", pack0(), 3'd1, RAM_OE | IR_LD | PC_INC);
    tick(); chk("step_hold_T1", pack0(), 3'd1, RAM_OE | IR_LD | PC_INC);
    step = 1'b1; tick(); step = 1'b0;
    chk("step_T2", pack0(), 3'd2, IR_OUT | MAR);
    step = 1'b1; tick(); step = 1'b0;
    chk("step_T3", pack0(), 3'd3, RAM_OE | B_LD);
    run = 1'b1; step = 1'b1;
    tick(); chk("runstep_T4", pack0(), 3'd4, ALU_EN | A_LD);
    tick(); chk("runstep_T0", pack0(), 3'd0, PC_OUT | MAR);
    step = 1'b0;

    // HLT
    reset = 1'b0;
    opcode = 4'hF;
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("hlt_T2", pack0(), 3'd2, NONE);
    tick(); chk("hlt_halt", pack0(), 3'd7, HALTED);
    run = 1'b0; step = 1'b1;
    tick(); tick();
    chk("hlt_step_ignored", pack0(), 3'd7, HALTED);
    run = 1'b1; step = 1'b0;
    tick(); chk("hlt_run_ignored", pack0(), 3'd7, HALTED);
    chk("hlt_full", pack1(), 3'd7, HALTED);
    reset = 1'b0;
    #1; chk("hlt_reset_async", pack0(), 3'd0, NONE);
    tick();
    reset = 1'b1;
    #1; chk("hlt_reset_T0", pack0(), 3'd0, PC_OUT | MAR);

    // Abort during ADD T3.
    opcode = 4'h1;
    tick(); tick(); tick();
    chk("abort_pre_T3", pack0(), 3'd3, RAM_OE | B_LD);
    #2;
    reset = 1'b0;
    #1; chk("abort_async", pack0(), 3'd0, NONE);
    tick(); chk("abort_hold", pack0(), 3'd0, NONE);
    reset = 1'b1;
    #1; chk("abort_resume_T0", pack0(), 3'd0, PC_OUT | MAR);
    tick(); chk("abort_resume_T1", pack0(), 3'd1, RAM_OE | IR_LD | PC_INC);

    // Random opcode/run/step; the monitor checks bus-driver exclusivity.
    for (int i = 0; i < 10000; i++) begin
      tick();
      opcode = 4'($urandom_range(0, 15));
      run    = 1'($urandom_range(0, 1));
      step   = 1'($urandom_range(0, 1));
      reset  = ((i % 256) == 255) ? 1'b0 : 1'b1;
    end
    reset = 1'b1;
    tick();

    vecs++;
    assert (mon_vecs > 10000) else begin
      fails++;
      $error("FAIL monitor_ran observed=%0d required=>10000", mon_vecs);
    end

    vecs  = vecs + mon_vecs;
    fails = fails + mon_fails;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
